// File: rtl/loader_pkg.sv
// Shared state type and default constants for the serial program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC   = 8'hA5;
  localparam int         LOADER_TIMEOUT = 1_000_000;

endpackage

// File: rtl/prog_loader_wordpack.sv
// Packs four little-endian bytes into one 32-bit instruction word.
module prog_loader_wordpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;

  // The 4th byte completes the word without waiting for the register.
  assign word_o       = {byte_i, sr_q[31:8]};
  assign word_valid_o = push_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      sr_q  <= 32'd0;
    end else if (clr_i) begin
      cnt_q <= 2'd0;
      sr_q  <= 32'd0;
    end else if (push_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= word_o;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial-link loader writing the instruction memory and gating core reset.
// Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] MAGIC       = LOADER_MAGIC,
  parameter int         TIMEOUT_CYC = LOADER_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int              TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     CAP  = 17'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL = CSUM;
`else
  localparam loader_state_t TAIL = DONE;
`endif

  loader_state_t     state_q, state_d;
  logic [15:0]       len_q;
  logic [16:0]       wcnt_q;
  logic [TW-1:0]     idle_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              err_q;

  logic        pk_push, pk_clr, pk_valid;
  logic [31:0] pk_word;
  logic [15:0] len_w;
  logic        active, last_w, too_big;

  assign len_w   = {rx_data, len_q[7:0]};
  assign too_big = {1'b0, len_w} > CAP;
  assign last_w  = (wcnt_q + 17'd1) == {1'b0, len_q};
  assign active  = state_q inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign pk_push = rx_valid && (state_q == DATA);
  assign pk_clr  = rx_valid && (state_q == LEN_HI);

  prog_loader_wordpack u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr),
    .push_i       (pk_push),
    .byte_i       (rx_data),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
    end else if (rx_valid) begin
      if (state_q inside {LEN_LO, LEN_HI, DATA})
        csum_q <= csum_q ^ rx_data;
      else if (state_q != CSUM)
        csum_q <= 8'd0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        IDLE, DONE, ERR:
          if (rx_data == MAGIC) state_d = LEN_LO;
        LEN_LO: state_d = LEN_HI;
        LEN_HI: begin
          if (len_w == 16'd0) state_d = TAIL;
          else if (too_big)   state_d = ERR;
          else                state_d = DATA;
        end
        DATA:
          if (pk_valid && last_w) state_d = TAIL;
`ifdef LOADER_CHECKSUM_EN
        CSUM:
          state_d = (rx_data == csum_q) ? DONE : ERR;
`endif
        default: state_d = IDLE;
      endcase
    end else if (active && (idle_q == TMAX)) begin
      state_d = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= 16'd0;
      wcnt_q  <= 17'd0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERR);
      we_q    <= pk_valid;
      if (pk_valid) wdata_q <= pk_word;
      if (!active || rx_valid) idle_q <= '0;
      else                     idle_q <= idle_q + 1'b1;
      if (rx_valid && state_q == LEN_LO) len_q[7:0]  <= rx_data;
      if (rx_valid && state_q == LEN_HI) len_q[15:8] <= rx_data;
      // Address advances after the pulse so it is stable while we is high.
      if (pk_clr) begin
        addr_q <= '0;
        wcnt_q <= 17'd0;
      end else begin
        if (we_q)     addr_q <= addr_q + 1'b1;
        if (pk_valid) wcnt_q <= wcnt_q + 17'd1;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = done_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the core's instruction memory over a serial link instead of a simulation-time hex preload. It sits between a UART receiver (byte-valid interface) and the instruction memory write port, and holds the pipelined core in reset until a complete, well-formed image has been written. It is the writer side of the instruction memory that the core's fetch stage reads.

## Interface
- `ADDR_W`, 10: instruction memory word-address width; capacity is 2^ADDR_W words.
- `MAGIC`, 8'hA5: frame start byte.
- `TIMEOUT_CYC`, 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data` in 8: received byte.
- `imem_we` out 1: instruction memory write enable, one-cycle pulse.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: write data.
- `core_rst_n` out 1: reset to the core; low while loading or on error.
- `load_done` out 1: high while a valid image is resident.
- `load_err` out 1: sticky error flag; cleared by the next magic byte.

## Operation
- Frame format: MAGIC, LEN_LO, LEN_HI, then LEN words of 4 bytes each (little-endian), then an optional checksum byte (see Configuration).
- States:
  - IDLE:
    - MAGIC → LEN_LO.
    - Any other byte is ignored.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI:
    - LEN == 0 → CSUM (macro on) or DONE (macro off).
    - LEN > 2^ADDR_W → ERR.
    - Otherwise → DATA, with the address counter and byte counter cleared.
  - DATA:
    - Shift each byte into bits [31:24] of the assembly register, shifting the rest right by 8, so byte 0 lands in [7:0].
    - On the 4th byte, issue a write and increment the address.
    - After word LEN−1 is written → CSUM or DONE.
  - CSUM:
    - Byte equals the running checksum → DONE.
    - Otherwise → ERR.
  - DONE:
    - `core_rst_n`=1 and `load_done`=1.
    - A MAGIC byte → LEN_LO: `core_rst_n` and `load_done` drop, and the core is reloaded.
    - Other bytes are ignored.
  - ERR:
    - `load_err`=1 and `core_rst_n`=0.
    - A MAGIC byte → LEN_LO and clears `load_err`.
- Timeout:
  - Applies in LEN_LO, LEN_HI, DATA and CSUM.
  - An idle counter resets on every `rx_valid`.
  - Reaching TIMEOUT_CYC−1 → ERR.
- LEN arithmetic: 16-bit unsigned; the comparison against 2^ADDR_W is done at 17 bits.
- A MAGIC byte received mid-frame is treated as data, not as a restart.

## Timing
- Reset values:
  - State IDLE.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_rst_n`=0, `load_done`=0, `load_err`=0.
- Every output is registered.
- `imem_we` pulses in the cycle after the `rx_valid` that carried the 4th byte of a word. `imem_addr` and `imem_wdata` are stable during that pulse.
- The address increments in the cycle after the pulse.
- `core_rst_n` and `load_done` rise one cycle after the final byte is accepted (last data byte, or checksum byte when the macro is on).
- Back-to-back `rx_valid` on every cycle is supported; no byte is dropped.
- Asserting `rst_n` mid-frame aborts the load immediately and returns to the reset values. Memory contents already written are left as they are.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit XOR accumulates over LEN_LO, LEN_HI and all data bytes.
  - A CSUM byte is required after the data.
  - A mismatch → ERR.
- `LOADER_CHECKSUM_EN` undefined:
  - No CSUM state and no accumulator.
  - DONE is entered directly after the last word, or after LEN_HI when LEN == 0.

## Structure
- `loader_pkg`:
  - State enum `loader_state_t` (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR).
  - Default constants `LOADER_MAGIC` and `LOADER_TIMEOUT`.
- Sub-module `prog_loader_wordpack`:
  - 2-bit byte counter plus 32-bit shift register.
  - Outputs `word_valid` on the 4th byte; has a clear input.
- FSM, address counter, timeout counter and checksum stay in `prog_loader`.

## Test plan
- Frame A5 02 00, then 13 00 00 00, then 93 00 10 00 (plus checksum 92 when the macro is on) → two `imem_we` pulses:
  - addr 0: 0x00000013.
  - addr 1: 0x00100093.
  - `load_done`=1 and `core_rst_n`=1 one cycle after the last byte.
- Same frame with checksum byte 00 (macro on) → ERR, `load_err`=1, `core_rst_n`=0. A following valid frame recovers to DONE.
- A5 01 08 with ADDR_W=10 (LEN=2049) → ERR after LEN_HI, with no `imem_we`.
- A5 00 00 (checksum 00 if the macro is on) → DONE with zero writes.
- A5 01 00 13 00, then silence for TIMEOUT_CYC cycles → ERR, no write. Bytes 55 AA before a MAGIC are ignored in IDLE.
- Assert `rst_n` after two data bytes → all outputs return to reset values. A fresh frame then writes from addr 0.
